// File: rtl/fmadd_pkg.sv
// Shared definitions for the FMADD multiply path: sequencer states and
// rounding-mode encodings.
package fmadd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // True when an overflowing result must saturate to infinity rather than max finite.
  function automatic logic rounds_to_inf(input logic [2:0] rm, input logic sign);
    return (rm == RM_RNE) || (rm == RM_RMM) ||
           ((rm == RM_RUP) && !sign) || ((rm == RM_RDN) && sign);
  endfunction

endpackage

// File: rtl/fmadd_mul_seq_multiplier_if.sv
// Operand/result handshake bundle for the sequential significand multiplier.
interface fmadd_mul_seq_multiplier_if #(
  parameter int std = 31,
  parameter int man = 22,
  parameter int exp = 7
);
  logic                   in_valid;
  logic                   in_ready;
  logic [std:0]           in_a;
  logic [std:0]           in_b;
  logic [2:0]             in_rm;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*man+exp+5:0]   out_no;
  logic                   out_overflow;
  logic                   out_sticky_PN;
  logic [2:0]             out_rm;

  modport master (
    output in_valid, in_a, in_b, in_rm, out_ready,
    input  in_ready, out_valid, out_no, out_overflow, out_sticky_PN, out_rm
  );

  modport slave (
    input  in_valid, in_a, in_b, in_rm, out_ready,
    output in_ready, out_valid, out_no, out_overflow, out_sticky_PN, out_rm
  );
endinterface

// File: rtl/fmadd_mul_shift_add.sv
// Radix-2 shift-add significand multiplier datapath; one multiplier bit per
// step, LSB first, with a down-counter flagging the final step.
module fmadd_mul_shift_add #(
  parameter int man = 22
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               start,
  input  logic               step,
  input  logic [man+1:0]     mcand_in,
  input  logic [man+1:0]     mplier_in,
  output logic               done,
  output logic [2*man+3:0]   product
);
  localparam int W  = man + 2;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_START = CW'(man + 1);

  logic [W-1:0]   mcand;
  logic [W-1:0]   mplier;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  cnt;
  logic [W:0]     sum;

  // Partial product lands in the upper half with its carry, then everything shifts right.
  assign sum = {1'b0, acc[2*W-1:W]} + (mplier[0] ? {1'b0, mcand} : {(W+1){1'b0}});

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= mcand_in;
      mplier <= mplier_in;
      acc    <= '0;
      cnt    <= CNT_START;
    end else if (step) begin
      acc    <= {sum, acc[W-1:1]};
      mplier <= mplier >> 1;
      if (cnt != '0) cnt <= cnt - CW'(1);
    end
  end

  assign done    = (cnt == '0);
  assign product = acc;

endmodule

// File: rtl/fmadd_mul_seq_multiplier.sv
// Multi-cycle FMADD significand multiplier: accepts two finite operands, produces
// the unrounded packed product plus overflow/flush flags for the rounding stage.
// States: IDLE accept | MUL shift-add | NORM normalize+exceptions | DONE hold result
module fmadd_mul_seq_multiplier
  import fmadd_pkg::*;
#(
  parameter int std  = 31,
  parameter int man  = 22,
  parameter int exp  = 7,
  parameter int bias = 127
) (
  input logic                      clk,
  input logic                      rst_l,
  fmadd_mul_seq_multiplier_if.slave bus
);
  localparam int W = man + 2;
  localparam logic [exp+2:0] BIAS_E = (exp+3)'(bias);
  localparam logic [exp+2:0] EMAX   = (exp+3)'((1 << (exp+1)) - 1);

  state_t state, state_nxt;
  logic start, step, mul_done;
  logic [2*W-1:0] product;

  logic           sign_q, zero_q;
  logic [2:0]     rm_q;
  logic [exp:0]   ea_q, eb_q;

  logic [exp:0]   exp_a, exp_b;
  logic [man:0]   frac_a, frac_b;

  assign exp_a  = bus.in_a[std-1:man+1];
  assign exp_b  = bus.in_b[std-1:man+1];
  assign frac_a = bus.in_a[man:0];
  assign frac_b = bus.in_b[man:0];

  fmadd_mul_shift_add #(.man(man)) u_shift_add (
    .clk       (clk),
    .rst_l     (rst_l),
    .start     (start),
    .step      (step),
    .mcand_in  ({|exp_a, frac_a}),
    .mplier_in ({|exp_b, frac_b}),
    .done      (mul_done),
    .product   (product)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: if (bus.in_valid) begin
        start     = 1'b1;
        state_nxt = MUL;
      end
      MUL: begin
        step = 1'b1;
        if (mul_done) state_nxt = NORM;
      end
      NORM: state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sign_q <= 1'b0;
      zero_q <= 1'b0;
      rm_q   <= '0;
      ea_q   <= '0;
      eb_q   <= '0;
    end else if (start) begin
      sign_q <= bus.in_a[std] ^ bus.in_b[std];
      zero_q <= (exp_a == '0) || (exp_b == '0);
      rm_q   <= bus.in_rm;
      ea_q   <= exp_a;
      eb_q   <= exp_b;
    end
  end

  // Exponent is kept in exp+3 bits two's complement; MSB set means negative.
  logic [exp+2:0] e_sum, e_norm;
  logic [2*W-1:0] sig_norm;
  logic [exp:0]   r_exp;
  logic [2*W-1:0] r_sig;
  logic           r_ovf, r_sticky;

  always_comb begin
    e_sum    = {2'b00, ea_q} + {2'b00, eb_q} - BIAS_E;
    e_norm   = product[2*W-1] ? e_sum + (exp+3)'(1) : e_sum;
    sig_norm = product[2*W-1] ? product : {product[2*W-2:0], 1'b0};
    r_exp    = e_norm[exp:0];
    r_sig    = sig_norm;
    r_ovf    = 1'b0;
    r_sticky = 1'b0;
    if (zero_q) begin
      r_exp = '0;
      r_sig = '0;
    end else if (e_norm[exp+2] || (e_norm == '0)) begin
      r_exp    = '0;
      r_sig    = '0;
      r_sticky = 1'b1;
    end else if (e_norm >= EMAX) begin
      r_ovf = 1'b1;
      if (rounds_to_inf(rm_q, sign_q)) begin
        r_exp = '1;
        r_sig = '0;
      end else begin
        r_exp = {{exp{1'b1}}, 1'b0};
        r_sig = {{W{1'b1}}, {W{1'b0}}};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      bus.out_no        <= '0;
      bus.out_overflow  <= 1'b0;
      bus.out_sticky_PN <= 1'b0;
      bus.out_rm        <= '0;
    end else if (state == NORM) begin
      bus.out_no        <= {sign_q, r_exp, r_sig};
      bus.out_overflow  <= r_ovf;
      bus.out_sticky_PN <= r_sticky;
      bus.out_rm        <= rm_q;
    end
  end

endmodule

// File: tb/tb_fmadd_mul_seq_multiplier.sv
// Directed-vector bench for the sequential FMADD significand multiplier.
module tb_fmadd_mul_seq_multiplier;
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  fmadd_mul_seq_multiplier_if #(.std(31), .man(22), .exp(7)) bus ();

  fmadd_mul_seq_multiplier #(.std(31), .man(22), .exp(7), .bias(127)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [47:0] SIG_MAX = {24'hFF_FFFF, 24'h00_0000};

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  task automatic accept_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
    @(negedge clk);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_rm    = rm;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = ~a;
    bus.in_b     = ~b;
    bus.in_rm    = ~rm;
  endtask

  task automatic wait_result(input string tag);
    int cyc = 0;
    while (!bus.out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_val({tag, ".lat"}, 64'(cyc), 64'd25);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] rm, input logic s, input logic [7:0] e,
                        input logic [47:0] sig, input logic ovf, input logic sticky);
    accept_op(a, b, rm);
    wait_result(tag);
    check_val({tag, ".no"},     64'(bus.out_no), 64'({s, e, sig}));
    check_val({tag, ".ovf"},    64'(bus.out_overflow), 64'(ovf));
    check_val({tag, ".sticky"}, 64'(bus.out_sticky_PN), 64'(sticky));
    check_val({tag, ".rm"},     64'(bus.out_rm), 64'(rm));
    @(posedge clk);
    #1;
    check_val({tag, ".idle"},   64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_rm     = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst.in_ready",  64'(bus.in_ready), 64'd1);
    check_val("rst.out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst.out_no",    64'(bus.out_no), 64'd0);
    check_val("rst.flags",     64'({bus.out_overflow, bus.out_sticky_PN}), 64'd0);
    check_val("rst.out_rm",    64'(bus.out_rm), 64'd0);
    rst_l = 1'b1;

    run_op("1p5x1p5",   32'h3FC00000, 32'h3FC00000, 3'b000, 1'b0, 8'h80, 48'h9000_0000_0000, 1'b0, 1'b0);
    run_op("1x-3",      32'h3F800000, 32'hC0400000, 3'b000, 1'b1, 8'h80, 48'hC000_0000_0000, 1'b0, 1'b0);
    run_op("2x3rmm",    32'h40000000, 32'h40400000, 3'b100, 1'b0, 8'h81, 48'hC000_0000_0000, 1'b0, 1'b0);
    run_op("ovf.rne",   32'h7F000000, 32'h7F000000, 3'b000, 1'b0, 8'hFF, 48'h0, 1'b1, 1'b0);
    run_op("ovf.rtz",   32'h7F000000, 32'h7F000000, 3'b001, 1'b0, 8'hFE, SIG_MAX, 1'b1, 1'b0);
    run_op("ovf.rup+",  32'h7F000000, 32'h7F000000, 3'b011, 1'b0, 8'hFF, 48'h0, 1'b1, 1'b0);
    run_op("ovf.rdn+",  32'h7F000000, 32'h7F000000, 3'b010, 1'b0, 8'hFE, SIG_MAX, 1'b1, 1'b0);
    run_op("ovf.rmm",   32'h7F000000, 32'h7F000000, 3'b100, 1'b0, 8'hFF, 48'h0, 1'b1, 1'b0);
    run_op("ovf.rdn-",  32'hFF000000, 32'h7F000000, 3'b010, 1'b1, 8'hFF, 48'h0, 1'b1, 1'b0);
    run_op("ovf.rup-",  32'hFF000000, 32'h7F000000, 3'b011, 1'b1, 8'hFE, SIG_MAX, 1'b1, 1'b0);
    run_op("e255",      32'h5F800000, 32'h5F800000, 3'b000, 1'b0, 8'hFF, 48'h0, 1'b1, 1'b0);
    run_op("e254",      32'h5F800000, 32'h5F000000, 3'b000, 1'b0, 8'hFE, 48'h8000_0000_0000, 1'b0, 1'b0);
    run_op("e253inc",   32'h5F400000, 32'h5F400000, 3'b000, 1'b0, 8'hFE, 48'h9000_0000_0000, 1'b0, 1'b0);
    run_op("e254inc",   32'h5F400000, 32'h5FC00000, 3'b001, 1'b0, 8'hFE, SIG_MAX, 1'b1, 1'b0);
    run_op("unf.min",   32'h00800000, 32'h00800000, 3'b000, 1'b0, 8'h00, 48'h0, 1'b0, 1'b1);
    run_op("unf.e0",    32'h3F000000, 32'h00800000, 3'b000, 1'b0, 8'h00, 48'h0, 1'b0, 1'b1);
    run_op("e1",        32'h3F800000, 32'h00800000, 3'b000, 1'b0, 8'h01, 48'h8000_0000_0000, 1'b0, 1'b0);
    run_op("zero",      32'h00000000, 32'hC0000000, 3'b000, 1'b1, 8'h00, 48'h0, 1'b0, 1'b0);
    run_op("subnorm",   32'h00400000, 32'h3F800000, 3'b000, 1'b0, 8'h00, 48'h0, 1'b0, 1'b0);

    // Backpressure: result must hold and new requests be ignored while DONE stalls.
    bus.out_ready = 1'b0;
    accept_op(32'h3FC00000, 32'h3FC00000, 3'b001);
    wait_result("bp");
    bus.in_valid = 1'b1;
    bus.in_a     = 32'h40000000;
    bus.in_b     = 32'h40400000;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check_val("bp.no",       64'(bus.out_no), 64'({1'b0, 8'h80, 48'h9000_0000_0000}));
      check_val("bp.in_ready", 64'(bus.in_ready), 64'd0);
    end
    check_val("bp.valid", 64'(bus.out_valid), 64'd1);
    check_val("bp.rm",    64'(bus.out_rm), 64'd1);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(posedge clk);
    #1;
    check_val("bp.rel.valid", 64'(bus.out_valid), 64'd0);
    check_val("bp.rel.ready", 64'(bus.in_ready), 64'd1);
    check_val("bp.rel.no",    64'(bus.out_no), 64'({1'b0, 8'h80, 48'h9000_0000_0000}));

    // Reset in the middle of MUL.
    accept_op(32'h40000000, 32'h40400000, 3'b000);
    repeat (5) @(posedge clk);
    #2;
    rst_l = 1'b0;
    #1;
    check_val("mrst.in_ready",  64'(bus.in_ready), 64'd1);
    check_val("mrst.out_valid", 64'(bus.out_valid), 64'd0);
    check_val("mrst.out_no",    64'(bus.out_no), 64'd0);
    @(negedge clk);
    rst_l = 1'b1;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) break;
    end
    check_val("mrst.no_output", 64'(bus.out_valid), 64'd0);
    run_op("post_rst", 32'h40000000, 32'h40400000, 3'b010, 1'b0, 8'h81, 48'hC000_0000_0000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
